// File: rtl/rng_pkg.sv
// rng_pkg: FSM encoding, reset seed and one-hot decode shared by rng_share_ctrl
package rng_pkg;
    typedef enum logic [1:0] {S_SEED, S_WARM, S_SERVE} state_e;
    localparam logic [31:0] SEED_DEFAULT = 32'd5489;
    function automatic logic [3:0] oh2idx(input logic [15:0] oh);
        oh2idx = '0;
        for (int i = 0; i < 16; i++) oh2idx = oh[i] ? 4'(i) : oh2idx;
    endfunction
endpackage

// File: rtl/register.sv
// Register: W-bit flop with synchronous active-high reset to RST
module Register #(
    parameter int W = 1,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) q <= rst ? RST : d;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr wins
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         win,
    output logic                 any
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] j;
    always_comb begin
        win = '0;
        j = '0;
        // scan from the farthest slot back towards ptr so the nearest requester is written last
        for (int k = N - 1; k >= 0; k--) begin
            j = PW'((int'(ptr) + k) % N);
            if (req[j]) win = N'(1) << j;
        end
    end
    assign any = |req;
endmodule

// File: rtl/rng_share_ctrl.sv
// rng_share_ctrl: shares one RNG word stream among NUM_REQ requesters, with reseed and warm-up discard
module rng_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int WARMUP = 624,
    parameter logic [31:0] SEED_DEFAULT = rng_pkg::SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rnd_out,
    input  logic [31:0]        seed_in,
    input  logic               seed_req,
    output logic               seed_ack,
    output logic               busy,
    input  logic [31:0]        rng_rnd,
    output logic               rng_adv,
    output logic [31:0]        rng_seed,
    output logic               rng_reseed
);
    import rng_pkg::*;
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [15:0] WLAST = 16'(WARMUP - 1);
    state_e             state_d, state_q;
    logic [1:0]         state_raw;
    logic               rst_q;
    logic [31:0]        seed_d, seed_q, rnd_d, rnd_q;
    logic [PW-1:0]      ptr_d, ptr_q;
    logic [15:0]        cnt_d, cnt_q;
    logic [NUM_REQ-1:0] gnt_d, gnt_q, win;
    logic               ack_d, ack_q, any, adv;

    rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req), .ptr(ptr_q), .win(win), .any(any));

    Register #(.W(2), .RST(2'(S_SEED))) u_state (.clk(clk), .rst(rst), .d(state_d), .q(state_raw));
    // high for the first cycle after reset so the reseed strobe lands one cycle later
    Register #(.W(1), .RST(1'b1)) u_rstq (.clk(clk), .rst(rst), .d(1'b0), .q(rst_q));
    Register #(.W(32), .RST(SEED_DEFAULT)) u_seed (.clk(clk), .rst(rst), .d(seed_d), .q(seed_q));
    Register #(.W(PW)) u_ptr (.clk(clk), .rst(rst), .d(ptr_d), .q(ptr_q));
    Register #(.W(16)) u_cnt (.clk(clk), .rst(rst), .d(cnt_d), .q(cnt_q));
    Register #(.W(NUM_REQ)) u_gnt (.clk(clk), .rst(rst), .d(gnt_d), .q(gnt_q));
    Register #(.W(32)) u_rnd (.clk(clk), .rst(rst), .d(rnd_d), .q(rnd_q));
    Register #(.W(1)) u_ack (.clk(clk), .rst(rst), .d(ack_d), .q(ack_q));

    assign state_q = state_e'(state_raw);

    always_comb begin
        state_d = state_q;
        seed_d = seed_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        gnt_d = '0;
        rnd_d = rnd_q;
        ack_d = 1'b0;
        adv = 1'b0;
        if (seed_req) begin
            state_d = S_SEED;
            seed_d = seed_in;
            cnt_d = '0;
            ack_d = 1'b1;
        end else if (state_q == S_SEED) begin
            state_d = rst_q ? S_SEED : (WARMUP > 0 ? S_WARM : S_SERVE);
            cnt_d = '0;
        end else if (state_q == S_WARM) begin
            adv = 1'b1;
            state_d = (cnt_q == WLAST) ? S_SERVE : S_WARM;
            cnt_d = (cnt_q == WLAST) ? '0 : cnt_q + 16'd1;
        end else if (any) begin
            adv = 1'b1;
            gnt_d = win;
            rnd_d = rng_rnd;
            ptr_d = PW'((int'(oh2idx(16'(win))) + 1) % NUM_REQ);
        end
    end

    assign gnt = gnt_q;
    assign rnd_out = rnd_q;
    assign seed_ack = ack_q;
    assign busy = rst | (state_q != S_SERVE);
    assign rng_adv = adv & ~rst;
    assign rng_seed = seed_q;
    assign rng_reseed = (state_q == S_SEED) & ~rst_q & ~rst;
endmodule

// File: tb/tb_rng_share_ctrl.sv
// tb_rng_share_ctrl: scoreboard bench for rng_share_ctrl driving a behavioural LCG generator
module tb_rng_share_ctrl;
    typedef struct packed {logic [3:0] g; logic [31:0] r;} exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  gnt;
    logic [31:0] rnd_out;
    logic [31:0] seed_in = '0;
    logic        seed_req = 1'b0;
    logic        seed_ack, busy, rng_adv, rng_reseed;
    logic [31:0] rng_seed;
    logic [31:0] gen = '0;
    logic [31:0] last_rnd = '0;
    int          m_ptr = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    always #5 clk = ~clk;

    rng_share_ctrl #(.NUM_REQ(4), .WARMUP(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rnd_out(rnd_out),
        .seed_in(seed_in), .seed_req(seed_req), .seed_ack(seed_ack), .busy(busy),
        .rng_rnd(gen), .rng_adv(rng_adv), .rng_seed(rng_seed), .rng_reseed(rng_reseed)
    );

    always @(posedge clk)
        gen <= rng_reseed ? rng_seed : (rng_adv ? gen * 32'd1664525 + 32'd1013904223 : gen);

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (gnt !== mon_e.g || rnd_out !== mon_e.r) begin
                errors++;
                $display("FAIL sb_grant: gnt=%b rnd_out=%h expected gnt=%b rnd_out=%h", gnt, rnd_out, mon_e.g, mon_e.r);
            end
        end else if (gnt !== 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL idle_grant: gnt=%b expected 0000", gnt);
        end
    end

    function automatic logic [3:0] rr_model(input logic [3:0] r, input int p);
        logic [3:0] b;
        rr_model = '0;
        for (int k = 3; k >= 0; k--) begin
            b = 4'b0001 << ((p + k) % 4);
            if ((r & b) != 4'b0000) rr_model = b;
        end
    endfunction

    task automatic exp_push(input logic [3:0] g);
        if (g != 4'b0000) last_rnd = gen;
        exp_q.push_back({g, last_rnd});
        for (int i = 0; i < 4; i++) if (g[i]) m_ptr = (i + 1) % 4;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        seed_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({gnt, rnd_out, seed_ack, rng_adv, rng_reseed, busy} !== {4'b0, 32'b0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b rnd=%h ack=%b adv=%b reseed=%b busy=%b expected zeros with busy=1",
                     gnt, rnd_out, seed_ack, rng_adv, rng_reseed, busy);
        end
        rst = 1'b0;
        last_rnd = '0;
        m_ptr = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if (rng_reseed !== (c == 1)) begin
                errors++;
                $display("FAIL boot_reseed c=%0d: got %b expected %b", c, rng_reseed, c == 1);
            end
            checks++;
            if (rng_adv !== (c >= 2 && c <= 5)) begin
                errors++;
                $display("FAIL boot_adv c=%0d: got %b expected %b", c, rng_adv, c >= 2 && c <= 5);
            end
            checks++;
            if (busy !== (c <= 5)) begin
                errors++;
                $display("FAIL boot_busy c=%0d: got %b expected %b", c, busy, c <= 5);
            end
            if (c == 1) begin
                checks++;
                if (rng_seed !== 32'd5489) begin
                    errors++;
                    $display("FAIL boot_seed: got %h expected %h", rng_seed, 32'd5489);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req = 4'b1111;
            exp_push(4'b0001 << (i % 4));
            #1;
            checks++;
            if (rng_adv !== 1'b1) begin
                errors++;
                $display("FAIL rr_adv i=%0d: got %b expected 1", i, rng_adv);
            end
        end
        @(negedge clk);
        req = '0;
        exp_push('0);
        #1;
        checks++;
        if (rng_adv !== 1'b0) begin
            errors++;
            $display("FAIL idle_adv: got %b expected 0", rng_adv);
        end
    endtask

    task automatic test_ptr_wrap();
        logic [3:0] rv[4] = '{4'b0010, 4'b0011, 4'b0011, 4'b0000};
        logic [3:0] ev[4] = '{4'b0010, 4'b0001, 4'b0010, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req = rv[i];
            exp_push(ev[i]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] r, g;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            r = 4'($urandom_range(0, 15));
            g = rr_model(r, m_ptr);
            req = r;
            exp_push(g);
            #1;
            checks++;
            if (rng_adv !== (r != 4'b0000)) begin
                errors++;
                $display("FAIL b2b_adv req=%b: got %b expected %b", r, rng_adv, r != 4'b0000);
            end
        end
        @(negedge clk);
        req = '0;
        exp_push('0);
    endtask

    task automatic test_seed_req();
        @(negedge clk);
        req = 4'b0001;
        seed_in = 32'h12345678;
        seed_req = 1'b1;
        exp_push('0);
        #1;
        checks++;
        if (rng_adv !== 1'b0) begin
            errors++;
            $display("FAIL seed_beats_req adv: got %b expected 0", rng_adv);
        end
        @(negedge clk);
        seed_req = 1'b0;
        req = '0;
        #1;
        checks++;
        if ({seed_ack, rng_reseed, busy, rng_seed} !== {3'b111, 32'h12345678}) begin
            errors++;
            $display("FAIL seed_cycle: ack=%b reseed=%b busy=%b seed=%h expected 1 1 1 12345678",
                     seed_ack, rng_reseed, busy, rng_seed);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({rng_adv, busy, seed_ack} !== {c < 4, c < 4, 1'b0}) begin
                errors++;
                $display("FAIL seed_warm c=%0d: adv=%b busy=%b ack=%b expected %b %b 0",
                         c, rng_adv, busy, seed_ack, c < 4, c < 4);
            end
        end
    endtask

    task automatic test_seed_mid_warm();
        @(negedge clk);
        seed_in = 32'hCAFEF00D;
        seed_req = 1'b1;
        @(negedge clk);
        seed_req = 1'b0;
        #1;
        checks++;
        if ({seed_ack, rng_reseed, rng_seed} !== {2'b11, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL mw_first_seed: ack=%b reseed=%b seed=%h expected 1 1 cafef00d", seed_ack, rng_reseed, rng_seed);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (rng_adv !== 1'b1) begin
                errors++;
                $display("FAIL mw_warm_adv: got %b expected 1", rng_adv);
            end
        end
        @(negedge clk);
        seed_in = 32'h0BADBEEF;
        seed_req = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mw_busy: got %b expected 1", busy);
        end
        @(negedge clk);
        seed_req = 1'b0;
        #1;
        checks++;
        if ({seed_ack, rng_reseed, rng_adv, rng_seed} !== {3'b110, 32'h0BADBEEF}) begin
            errors++;
            $display("FAIL mw_reseed: ack=%b reseed=%b adv=%b seed=%h expected 1 1 0 0badbeef",
                     seed_ack, rng_reseed, rng_adv, rng_seed);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({rng_adv, busy} !== {c < 4, c < 4}) begin
                errors++;
                $display("FAIL mw_restart c=%0d: adv=%b busy=%b expected %b %b", c, rng_adv, busy, c < 4, c < 4);
            end
        end
    endtask

    task automatic test_reset_mid_serve();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req = 4'b1111;
            exp_push(rr_model(4'b1111, m_ptr));
        end
        @(negedge clk);
        rst = 1'b1;
        last_rnd = '0;
        m_ptr = 0;
        exp_push('0);
        #1;
        checks++;
        if (rng_adv !== 1'b0) begin
            errors++;
            $display("FAIL rst_adv: got %b expected 0", rng_adv);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_push('0);
        #1;
        checks++;
        if ({rng_reseed, busy} !== 2'b01) begin
            errors++;
            $display("FAIL rst_after: reseed=%b busy=%b expected 0 1", rng_reseed, busy);
        end
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            exp_push('0);
            #1;
            checks++;
            if (c == 1 && {rng_reseed, rng_seed} !== {1'b1, 32'd5489}) begin
                errors++;
                $display("FAIL rst_reseed: reseed=%b seed=%h expected 1 %h", rng_reseed, rng_seed, 32'd5489);
            end else if (c > 1 && rng_adv !== 1'b1) begin
                errors++;
                $display("FAIL rst_warm c=%0d: adv=%b expected 1", c, rng_adv);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_push(4'b0001 << i);
        end
        @(negedge clk);
        req = '0;
        exp_push('0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ptr_wrap();
        test_back_to_back();
        test_seed_req();
        test_seed_mid_warm();
        test_reset_mid_serve();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rng_share_ctrl.md
RNG_SHARE_CTRL -- requirements
Module: rng_share_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..16.
REQ-002 SHALL have parameter WARMUP, default 624: outputs discarded after each (re)seed, 0..65535.
REQ-003 SHALL have parameter SEED_DEFAULT, default 32'd5489: seed applied after reset.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  in  NUM_REQ  per-requester level; each cycle high = one word wanted.
REQ-007 SHALL have port gnt  out  NUM_REQ  registered one-hot grant, rnd_out valid while any bit set.
REQ-008 SHALL have port rnd_out  out  32  registered random word for the granted requester.
REQ-009 SHALL have port seed_in  in  32  new seed, sampled when seed_req=1.
REQ-010 SHALL have port seed_req  in  1  single-cycle pulse requesting reseed.
REQ-011 SHALL have port seed_ack  out  1  one-cycle pulse, cycle after seed_req accepted.
REQ-012 SHALL have port busy  out  1  high in SEED and WARM states.
REQ-013 SHALL have port rng_rnd  in  32  current generator output word.
REQ-014 SHALL have port rng_adv  out  1  generator advance strobe; one word consumed per high cycle.
REQ-015 SHALL have port rng_seed  out  32  seed to generator, valid when rng_reseed=1.
REQ-016 SHALL have port rng_reseed  out  1  generator reseed strobe.

Function
REQ-017 SHALL implement FSM states SEED, WARM, SERVE.
REQ-018 SEED: lasts one cycle; rng_reseed=1, rng_seed=latched seed; next WARM if WARMUP>0, else SERVE.
REQ-019 WARM: rng_adv=1 every cycle, no grants; counter from 0; leave for SERVE the cycle after count reaches WARMUP-1 (exactly WARMUP advances).
REQ-020 SERVE: if seed_req=0 and any req bit high, select one winner round-robin starting at pointer ptr; rng_adv=1 that cycle.
REQ-021 Winner's gnt bit and rnd_out = rng_rnd sampled in decision cycle SHALL appear the following cycle (latency 1); gnt=0 otherwise.
REQ-022 ptr SHALL become (winner+1) mod NUM_REQ after every grant; unchanged when no grant.
REQ-023 rng_adv SHALL be 0 in SERVE when no grant is made; each generator word delivered at most once.
REQ-024 At most one gnt bit per cycle; with all req high, each requester SHALL receive exactly one grant per NUM_REQ consecutive grants.
REQ-025 seed_req in any state: latch seed_in, next state SEED, seed_ack=1 next cycle, warm counter cleared; no grant decision that cycle (seed_req beats req).
REQ-026 seed_req during SEED or WARM SHALL restart the sequence with the newer seed.
REQ-027 rnd_out SHALL hold its last value when gnt=0.

Reset
REQ-028 rst=1 SHALL force next state SEED, seed latch=SEED_DEFAULT, ptr=0, warm counter=0.
REQ-029 While rst=1 and the cycle after: gnt=0, rnd_out=0, seed_ack=0, rng_adv=0, rng_reseed=0; busy=1.
REQ-030 rst mid-WARM or mid-SERVE SHALL discard pending grant and pending seed_req.

Structure
REQ-031 FSM state enum and SEED_DEFAULT SHALL live in shared package rng_pkg.
REQ-032 Round-robin select SHALL be sub-module rr_arbiter (req, ptr -> one-hot winner, any), combinational.
REQ-033 Output, state, ptr and counter flops SHALL use the common Register module.

Verification
REQ-034 Reset, WARMUP=4, no req: rng_reseed high 1 cycle with rng_seed=5489, then rng_adv high exactly 4 cycles, busy falls; gnt stays 0.
REQ-035 SERVE, req=4'b1111 for 8 cycles: gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000, each rnd_out equal to rng_rnd one cycle earlier.
REQ-036 SERVE, ptr=2, req=4'b0011: gnt=0001 then ptr=1; next cycle gnt=0010.
REQ-037 seed_req with seed_in=32'h12345678 and req=4'b0001 same cycle: no gnt next cycle, seed_ack=1, rng_reseed with rng_seed=32'h12345678, busy until warm-up done.
REQ-038 seed_req mid-WARM (count=2 of 4): new SEED cycle, full 4-cycle warm-up restarts.
REQ-039 rst asserted during SERVE with req=4'b1111: gnt=0 following cycle, ptr returns to 0, sequence restarts with seed 5489.
